// File: rtl/disp_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment display interface.
// Segment encodings (active-low, bit6=g .. bit0=a) match the display driver's
// encoder; select codes are active-low one-cold.
package disp_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    // Error glyph the driver shows for out-of-range input; never a digit.
    localparam logic [SEG_W-1:0] SEG_ERR = 7'b1000001;

    localparam logic [SEL_W-1:0] SEL_MIN0  = 4'b0111;
    localparam logic [SEL_W-1:0] SEL_MIN1  = 4'b1011;
    localparam logic [SEL_W-1:0] SEL_HOUR0 = 4'b1101;
    localparam logic [SEL_W-1:0] SEL_HOUR1 = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] hour1;
        logic [3:0] hour0;
        logic [2:0] min1;
        logic [3:0] min0;
    } clock_digits_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment (active-low) to BCD decoder, inverse of the driver encoder.
//   seg     : segment lines, bit6=g .. bit0=a
//   value_c : decoded digit 0..9 (0 when invalid)
//   valid_c : pattern is one of the ten digit glyphs
module seg7_to_bcd
    import disp_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [BCD_W-1:0] value_c,
    output logic             valid_c
);

    always_comb begin
        value_c = '0;
        valid_c = 1'b1;
        case (seg)
            SEG_0:   value_c = 4'd0;
            SEG_1:   value_c = 4'd1;
            SEG_2:   value_c = 4'd2;
            SEG_3:   value_c = 4'd3;
            SEG_4:   value_c = 4'd4;
            SEG_5:   value_c = 4'd5;
            SEG_6:   value_c = 4'd6;
            SEG_7:   value_c = 4'd7;
            SEG_8:   value_c = 4'd8;
            SEG_9:   value_c = 4'd9;
            SEG_ERR: valid_c = 1'b0;
            default: valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/disp_scan_decoder.sv
// Loopback monitor for the multiplexed 4-digit 7-segment clock display.
// Captures settled digits, assembles a frame, and publishes hour1/hour0/min1/min0
// atomically when a complete error-free frame has been seen.
//   clk, rst_n           : clock, async active-low reset
//   disp_num/sel/dot     : raw display lines (active-low), synchronised internally
//   hour1..min0          : last committed time
//   time_valid           : outputs hold a complete, current frame
//   frame_done           : one-cycle pulse on output update
//   err_seg/sel/dot/range: sticky error flags, cleared by err_clr
module disp_scan_decoder
    import disp_pkg::*;
#(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] disp_num,
    input  logic [SEL_W-1:0] disp_sel,
    input  logic             disp_dot,
    output logic [1:0]       hour1,
    output logic [3:0]       hour0,
    output logic [2:0]       min1,
    output logic [3:0]       min0,
    output logic             time_valid,
    output logic             frame_done,
    output logic             err_seg,
    output logic             err_sel,
    output logic             err_dot,
    output logic             err_range,
    input  logic             err_clr
);

    localparam int unsigned          CNT_W   = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(SETTLE);
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

    // Two-flop synchroniser plus a one-cycle-delayed copy for change detection.
    // Reset to the idle (all-off) levels of the display lines.
    logic [SEG_W-1:0] num_s1, num_s2, num_q;
    logic [SEL_W-1:0] sel_s1, sel_s2, sel_q;
    logic             dot_s1, dot_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_s1 <= '1;
            num_s2 <= '1;
            num_q  <= '1;
            sel_s1 <= '1;
            sel_s2 <= '1;
            sel_q  <= '1;
            dot_s1 <= 1'b1;
            dot_s2 <= 1'b1;
        end else begin
            num_s1 <= disp_num;
            num_s2 <= num_s1;
            num_q  <= num_s2;
            sel_s1 <= disp_sel;
            sel_s2 <= sel_s1;
            sel_q  <= sel_s2;
            dot_s1 <= disp_dot;
            dot_s2 <= dot_s1;
        end
    end

    // Settle counter: capture fires once as it saturates at SETTLE.
    logic [CNT_W-1:0] settle_cnt;
    logic             changed_c;
    logic             capture_c;

    assign changed_c = (num_s2 != num_q) || (sel_s2 != sel_q);
    assign capture_c = !changed_c && (settle_cnt == CNT_MAX - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (changed_c) begin
            settle_cnt <= '0;
        end else if (settle_cnt != CNT_MAX) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    logic [BCD_W-1:0] dec_val_c;
    logic             dec_ok_c;

    seg7_to_bcd u_dec (
        .seg     (num_s2),
        .value_c (dec_val_c),
        .valid_c (dec_ok_c)
    );

    // Frame state
    state_t                 state, state_d;
    logic [3:0]             mask, mask_d;
    logic                   frame_bad, frame_bad_d;
    clock_digits_t          shadow, shadow_d;
    clock_digits_t          disp_q, disp_d;
    logic                   time_valid_d, frame_done_d;
    logic                   err_seg_d, err_sel_d, err_dot_d, err_range_d;
    logic [TIMEOUT_W-1:0]   wd, wd_d;
    logic                   seg_set, sel_set, dot_set, range_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            frame_bad  <= 1'b0;
            shadow     <= '0;
            disp_q     <= '0;
            time_valid <= 1'b0;
            frame_done <= 1'b0;
            err_seg    <= 1'b0;
            err_sel    <= 1'b0;
            err_dot    <= 1'b0;
            err_range  <= 1'b0;
            wd         <= '0;
        end else begin
            state      <= state_d;
            mask       <= mask_d;
            frame_bad  <= frame_bad_d;
            shadow     <= shadow_d;
            disp_q     <= disp_d;
            time_valid <= time_valid_d;
            frame_done <= frame_done_d;
            err_seg    <= err_seg_d;
            err_sel    <= err_sel_d;
            err_dot    <= err_dot_d;
            err_range  <= err_range_d;
            wd         <= wd_d;
        end
    end

    // Next-state: capture handling, commit/discard, watchdog timeout.
    always_comb begin
        state_d      = state;
        mask_d       = mask;
        frame_bad_d  = frame_bad;
        shadow_d     = shadow;
        disp_d       = disp_q;
        time_valid_d = time_valid;
        frame_done_d = 1'b0;
        wd_d         = wd;
        seg_set      = 1'b0;
        sel_set      = 1'b0;
        dot_set      = 1'b0;
        range_set    = 1'b0;

        if (capture_c) begin
            wd_d = '0;
        end else if (wd != WD_MAX) begin
            wd_d = wd + TIMEOUT_W'(1);
        end

        // Commit clears the frame first so a same-cycle capture starts the next one.
        if (state == COMMIT) begin
            if (!frame_bad) begin
                disp_d       = shadow;
                frame_done_d = 1'b1;
                time_valid_d = 1'b1;
            end else begin
                time_valid_d = 1'b0;
            end
            mask_d      = '0;
            frame_bad_d = 1'b0;
        end

        if (capture_c) begin
            case (sel_s2)
                SEL_HOUR1: begin
                    shadow_d.hour1 = 2'(dec_val_c);
                    mask_d[3]      = 1'b1;
                    range_set      = dec_val_c > 4'd2;
                end
                SEL_HOUR0: begin
                    shadow_d.hour0 = dec_val_c;
                    mask_d[2]      = 1'b1;
                end
                SEL_MIN1: begin
                    shadow_d.min1 = 3'(dec_val_c);
                    mask_d[1]     = 1'b1;
                    range_set     = dec_val_c > 4'd5;
                end
                SEL_MIN0: begin
                    shadow_d.min0 = dec_val_c;
                    mask_d[0]     = 1'b1;
                end
                default: sel_set = 1'b1;
            endcase
            if (!sel_set) begin
                seg_set = !dec_ok_c;
                // Dot is lit (low) only between hours and minutes.
                dot_set = dot_s2 != (sel_s2 != SEL_HOUR0);
                if (seg_set || range_set) begin
                    frame_bad_d = 1'b1;
                end
            end
        end

        case (state)
            IDLE:    if (capture_c) state_d = COLLECT;
            COLLECT: if (mask == 4'hF) state_d = COMMIT;
            COMMIT:  state_d = COLLECT;
            default: state_d = IDLE;
        endcase

        // Stale display: drop validity and the partial frame, keep outputs.
        if (wd == WD_MAX && !capture_c) begin
            state_d      = IDLE;
            mask_d       = '0;
            frame_bad_d  = 1'b0;
            time_valid_d = 1'b0;
        end

        err_seg_d   = err_clr ? 1'b0 : (err_seg   | seg_set);
        err_sel_d   = err_clr ? 1'b0 : (err_sel   | sel_set);
        err_dot_d   = err_clr ? 1'b0 : (err_dot   | dot_set);
        err_range_d = err_clr ? 1'b0 : (err_range | range_set);
    end

    assign hour1 = disp_q.hour1;
    assign hour0 = disp_q.hour0;
    assign min1  = disp_q.min1;
    assign min0  = disp_q.min0;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Directed bench for disp_scan_decoder: drives display scans, queues the expected
// time for every frame that should commit, and checks each frame_done against it.
module tb_disp_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] disp_num;
    logic [3:0] disp_sel;
    logic       disp_dot;
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic       time_valid, frame_done;
    logic       err_seg, err_sel, err_dot, err_range;
    logic       err_clr;

    disp_scan_decoder #(.SETTLE(4), .TIMEOUT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_num   (disp_num),
        .disp_sel   (disp_sel),
        .disp_dot   (disp_dot),
        .hour1      (hour1),
        .hour0      (hour0),
        .min1       (min1),
        .min0       (min0),
        .time_valid (time_valid),
        .frame_done (frame_done),
        .err_seg    (err_seg),
        .err_sel    (err_sel),
        .err_dot    (err_dot),
        .err_range  (err_range),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    localparam logic [3:0] S_H1 = 4'b1110;
    localparam logic [3:0] S_H0 = 4'b1101;
    localparam logic [3:0] S_M1 = 4'b1011;
    localparam logic [3:0] S_M0 = 4'b0111;
    localparam logic [6:0] P_ERR = 7'b1000001;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [3:0] s, input logic [6:0] n, input logic d, input int cyc);
        disp_sel = s;
        disp_num = n;
        disp_dot = d;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // dots: [3]=hour1 [2]=hour0 [1]=min1 [0]=min0, active-low
    task automatic scan_raw(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                            input logic [6:0] p0, input logic [3:0] dots);
        put(S_H1, p3, dots[3], 8);
        put(S_H0, p2, dots[2], 8);
        put(S_M1, p1, dots[1], 8);
        put(S_M0, p0, dots[0], 8);
    endtask

    task automatic scan(input int h1, input int h0, input int m1, input int m0,
                        input logic [3:0] dots, input bit good);
        exp_t e;
        if (good) begin
            e = '{h1: 2'(h1), h0: 4'(h0), m1: 3'(m1), m0: 4'(m0)};
            exp_q.push_back(e);
        end
        scan_raw(enc(h1), enc(h0), enc(m1), enc(m0), dots);
    endtask

    // Scoreboard: every frame_done must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_frame_done: observed %0d:%0d%0d:%0d expected no frame",
                       hour1, hour0, min1, min0);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_hour1", 32'(hour1), 32'(e.h1));
                check("frame_hour0", 32'(hour0), 32'(e.h0));
                check("frame_min1",  32'(min1),  32'(e.m1));
                check("frame_min0",  32'(min0),  32'(e.m0));
            end
            done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        err_clr  = 1'b0;
        disp_sel = 4'b1111;
        disp_num = 7'b1111111;
        disp_dot = 1'b1;
        wait_cyc(3);
        check("rst_hour1", 32'(hour1), 0);
        check("rst_min0", 32'(min0), 0);
        check("rst_time_valid", 32'(time_valid), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_errs", 32'({err_seg, err_sel, err_dot, err_range}), 0);
        rst_n = 1'b1;

        // Glitching segments on hour1 never settle; the stable 1 that follows does.
        disp_sel = S_H1;
        disp_dot = 1'b1;
        for (int i = 0; i < 6; i++) begin
            disp_num = (i % 2 == 0) ? P_ERR : enc(9);
            repeat (2) @(negedge clk);
        end
        scan(1, 2, 4, 7, 4'b1011, 1'b1);
        wait_cyc(6);
        check("glitch_done_cnt", 32'(done_cnt), 1);
        check("glitch_hour1", 32'(hour1), 1);
        check("glitch_err_seg", 32'(err_seg), 0);
        check("glitch_err_range", 32'(err_range), 0);

        // Clean 21:35
        scan(2, 1, 3, 5, 4'b1011, 1'b1);
        wait_cyc(6);
        check("t2135_done_cnt", 32'(done_cnt), 2);
        check("t2135_time_valid", 32'(time_valid), 1);
        check("t2135_errs", 32'({err_seg, err_sel, err_dot, err_range}), 0);

        // Error glyph on min0: frame dropped, outputs hold 21:35
        scan_raw(enc(2), enc(1), enc(3), P_ERR, 4'b1011);
        wait_cyc(6);
        check("badseg_err_seg", 32'(err_seg), 1);
        check("badseg_time_valid", 32'(time_valid), 0);
        check("badseg_hour1_hold", 32'(hour1), 2);
        check("badseg_min0_hold", 32'(min0), 5);
        check("badseg_done_cnt", 32'(done_cnt), 2);

        // Clean 09:59 recovers validity; err_seg stays sticky until cleared
        scan(0, 9, 5, 9, 4'b1011, 1'b1);
        wait_cyc(6);
        check("t0959_done_cnt", 32'(done_cnt), 3);
        check("t0959_time_valid", 32'(time_valid), 1);
        check("t0959_err_seg_sticky", 32'(err_seg), 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check("clr_err_seg", 32'(err_seg), 0);

        // min1 = 7 is out of range: frame discarded
        scan(2, 1, 7, 5, 4'b1011, 1'b0);
        wait_cyc(6);
        check("range_err_range", 32'(err_range), 1);
        check("range_time_valid", 32'(time_valid), 0);
        check("range_min1_hold", 32'(min1), 5);
        check("range_done_cnt", 32'(done_cnt), 3);

        // Illegal select in place of min0 must not complete the frame
        put(S_H1, enc(2), 1'b1, 8);
        put(S_H0, enc(3), 1'b0, 8);
        put(S_M1, enc(5), 1'b1, 8);
        put(4'b0011, enc(8), 1'b1, 8);
        wait_cyc(4);
        check("illsel_err_sel", 32'(err_sel), 1);
        check("illsel_no_frame", 32'(done_cnt), 3);
        exp_q.push_back('{h1: 2'd2, h0: 4'd3, m1: 3'd5, m0: 4'd8});
        put(S_M0, enc(8), 1'b1, 8);
        wait_cyc(6);
        check("t2358_done_cnt", 32'(done_cnt), 4);
        check("t2358_time_valid", 32'(time_valid), 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check("clr_err_sel", 32'(err_sel), 0);
        check("clr_err_range", 32'(err_range), 0);

        // Dot low on min0: err_dot but the frame still commits
        scan(1, 4, 2, 0, 4'b1010, 1'b1);
        wait_cyc(6);
        check("dot_done_cnt", 32'(done_cnt), 5);
        check("dot_err_dot", 32'(err_dot), 1);
        check("dot_time_valid", 32'(time_valid), 1);
        check("dot_err_seg", 32'(err_seg), 0);

        // Static inputs: watchdog (63 cycles) drops time_valid, outputs hold
        n = 0;
        while (time_valid === 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("wd_time_valid_dropped", 32'(time_valid), 0);
        check("wd_not_early", 32'(n >= 45 && n <= 64), 1);
        check("wd_hour0_hold", 32'(hour0), 4);
        check("wd_min1_hold", 32'(min1), 2);

        // Reset mid-frame clears everything asynchronously
        put(S_H1, enc(2), 1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hour0", 32'(hour0), 0);
        check("arst_min1", 32'(min1), 0);
        check("arst_time_valid", 32'(time_valid), 0);
        check("arst_err_dot", 32'(err_dot), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_decoder.md
Name: disp_scan_decoder

Overview:
- Receives the multiplexed 4-digit 7-segment interface produced by the clock display driver: active-low segments, active-low one-cold digit select and a decimal-point line.
- Reconstructs the displayed time as hour1/hour0/min1/min0, with frame-valid and error status.
- Used as an on-chip loopback monitor and as a self-check block in system benches.
- Samples only settled digits and publishes the four digits atomically once a complete, error-free frame has been captured.

Parameters:
- SETTLE, 4: consecutive cycles with select and segments unchanged before a digit is captured (≥1).
- TIMEOUT_W, 20: width of the activity watchdog counter; stale after 2^TIMEOUT_W−1 cycles without a capture.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- disp_num  in  7  segment lines, active-low, bit6=g … bit0=a
- disp_sel  in  4  digit select, active-low: 0111=min0, 1011=min1, 1101=hour0, 1110=hour1
- disp_dot  in  1  decimal point, active-low
- hour1  out  2  decoded tens of hours
- hour0  out  4  decoded units of hours
- min1  out  3  decoded tens of minutes
- min0  out  4  decoded units of minutes
- time_valid  out  1  level; outputs hold a complete, current frame
- frame_done  out  1  one-cycle pulse when outputs update
- err_seg  out  1  sticky; an unrecognised segment pattern was captured
- err_sel  out  1  sticky; an illegal select code persisted for SETTLE cycles
- err_dot  out  1  sticky; dot state disagreed with select
- err_range  out  1  sticky; hour1>2, min1>5, or a digit too wide for its port
- err_clr  in  1  synchronous clear of all sticky errors

Behaviour:
- Reset: all digit outputs 0; time_valid, frame_done and all err_* 0; settle counter 0; capture mask 0; watchdog 0.
- Input stage: disp_num, disp_sel and disp_dot pass through a 2-flop synchroniser. All decisions use the synchronised copies. Input-to-capture latency is 2+SETTLE cycles.
- Settle counter:
  - Cleared whenever synchronised sel or num differs from the previous cycle; otherwise increments, saturating at SETTLE.
  - Capture fires once, on the cycle the counter reaches SETTLE. The same digit is never recaptured until sel changes.
- Segment decode (active-low): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9. Any other pattern, including the driver's 1000001 error glyph, is invalid.
- On capture with a legal select:
  - Write the decoded value into the shadow register for that digit and set its mask bit.
  - Invalid pattern: set err_seg and frame_bad.
  - Dot must be low iff sel=1101. A mismatch sets err_dot only; the frame is still accepted.
  - Range: hour1 digit >2 or min1 digit >5 sets err_range and frame_bad.
- On capture with an illegal select: set err_sel; mask and shadows are untouched.
- Frame completion: the cycle after the mask reaches 1111:
  - If frame_bad=0: copy shadows to outputs, pulse frame_done, set time_valid.
  - If frame_bad=1: outputs hold and time_valid clears.
  - In both cases the mask and frame_bad clear, and a new frame starts.
- Recapture of an already-masked digit before completion (out-of-order scan): overwrite the shadow and keep the mask. No error.
- Watchdog: reset on every capture and increments otherwise. At all-ones it clears time_valid and the mask and holds until the next capture. Outputs keep their last values.
- err_clr has priority over a same-cycle error set, i.e. the clear wins.
- Reset asserted mid-frame aborts the frame immediately. Outputs return to the reset values.
- State machine:
  - IDLE: no capture since reset or timeout.
  - COLLECT: mask ≠ 1111.
  - COMMIT: one cycle, update or discard.
  - Transitions: IDLE→COLLECT on the first capture; COLLECT→COMMIT when mask=1111; COMMIT→COLLECT; any→IDLE on timeout.

Decomposition:
- Shared package disp_pkg holds:
  - the segment encoding constants, shared with the display driver;
  - the select codes SEL_MIN0/SEL_MIN1/SEL_HOUR0/SEL_HOUR1;
  - the state enum IDLE/COLLECT/COMMIT.
- One natural sub-module: seg7_to_bcd. It is combinational: segments in, 4-bit value and valid flag out. It mirrors the driver's encoder.

Test Plan:
- Drive a scan of 21:35 (sel 1110/1101/1011/0111 with the matching patterns, dot low on 1101), each digit held 8 cycles, SETTLE=4 → frame_done pulses once. Outputs: hour1=2, hour0=1, min1=3, min0=5. time_valid=1, no errors.
- Glitch: segments change every 2 cycles within one select window, SETTLE=4 → no capture and no frame_done. Then a stable 1111001 → captured as 1.
- Pattern 1000001 on min0 within a complete scan → err_seg=1 and time_valid=0. Outputs keep the previous 21:35. The next clean 09:59 frame → outputs 0,9,5,9 and time_valid=1; err_seg stays 1 until err_clr.
- min1 pattern for 7 → err_range=1 and the frame is discarded. sel=0011 held 8 cycles → err_sel=1 with no mask change.
- Dot held low on sel=0111 → err_dot=1, and the frame still commits.
- After a valid frame, hold inputs static with TIMEOUT_W=6 → time_valid drops after 63 cycles. Assert rst_n=0 mid-frame → all outputs 0 asynchronously.
